// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, byte constants and round-robin helper for uart_line_arbiter
package uart_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOCK,
      ST_PFX0,
      ST_PFX1,
      ST_PFX2,
      ST_PFX3
   } arb_state_t;

   localparam logic [7:0] NEWLINE        = 8'h0A;
   localparam logic [7:0] PFX_OPEN       = 8'h5B;
   localparam logic [7:0] PFX_CLOSE      = 8'h5D;
   localparam logic [7:0] PFX_SPACE      = 8'h20;
   localparam logic [7:0] PFX_DIGIT_BASE = 8'h30;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_arb_fifo.sv
// rtl/uart_arb_fifo.sv - per-source character FIFO; a push into a full FIFO lands only if it is popped that cycle
module uart_arb_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_line_arbiter.sv
// rtl/uart_line_arbiter.sv - merges per-hart UART streams, holding each grant until a newline or timeout
// Optional macro UART_ARB_PREFIX_EN: each grant is preceded by "[n] " on the output.
module uart_line_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_SRC      = 2,
   parameter int FIFO_DEPTH   = 16,
   parameter int LOCK_TIMEOUT = 256,
   localparam int SW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_SRC-1:0]   src_valid,
   input  logic [8*NUM_SRC-1:0] src_ch,
   output logic                 out_valid,
   output logic [7:0]           out_ch,
   output logic [SW-1:0]        out_src,
   input  logic                 out_ready,
   output logic [NUM_SRC-1:0]   src_overflow
);

   localparam int TW = $clog2(LOCK_TIMEOUT + 1);

   arb_state_t         state;
   arb_state_t         state_d;
   logic [SW-1:0]      grant;
   logic [SW-1:0]      grant_d;
   logic [SW-1:0]      last_grant;
   logic [SW-1:0]      last_grant_d;
   logic [TW-1:0]      tmo_cnt;
   logic [TW-1:0]      tmo_d;
   logic [NUM_SRC-1:0] full;
   logic [NUM_SRC-1:0] empty;
   logic [NUM_SRC-1:0] pop;
   logic [7:0]         head [NUM_SRC];
   logic [7:0]         grant_head;
   logic               grant_empty;
   logic               scan_hit;
   logic [SW-1:0]      scan_idx;
   logic [SW-1:0]      cand;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      uart_arb_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (8)
      ) u_fifo (
         .clock (clock),
         .reset (reset),
         .push  (src_valid[i]),
         .pop   (pop[i]),
         .din   (src_ch[8*i +: 8]),
         .full  (full[i]),
         .empty (empty[i]),
         .head  (head[i])
      );
   end

   assign grant_head  = head[grant];
   assign grant_empty = empty[grant];
   assign out_src     = grant;

   // First non-empty source after the previous owner wins.
   always_comb begin
      scan_hit = 1'b0;
      scan_idx = '0;
      cand     = SW'(rr_next(int'(last_grant), NUM_SRC));
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!scan_hit && !empty[cand]) begin
            scan_hit = 1'b1;
            scan_idx = cand;
         end
         cand = SW'(rr_next(int'(cand), NUM_SRC));
      end
   end

   always_comb begin
      state_d      = state;
      grant_d      = grant;
      last_grant_d = last_grant;
      tmo_d        = tmo_cnt;
      pop          = '0;
      out_valid    = 1'b0;
      out_ch       = 8'h00;
      case (state)
         ST_IDLE: begin
            if (scan_hit) begin
               grant_d = scan_idx;
               tmo_d   = '0;
`ifdef UART_ARB_PREFIX_EN
               state_d = ST_PFX0;
`else
               state_d = ST_LOCK;
`endif
            end
         end
         ST_LOCK: begin
            out_valid = !grant_empty;
            out_ch    = grant_empty ? 8'h00 : grant_head;
            if (!grant_empty && out_ready) begin
               pop[grant] = 1'b1;
               tmo_d      = '0;
               if (grant_head == NEWLINE) begin
                  state_d      = ST_IDLE;
                  last_grant_d = grant;
               end
            end else if (tmo_cnt == TW'(LOCK_TIMEOUT)) begin
               // Source went quiet without a newline: hand the console to others.
               state_d      = ST_IDLE;
               last_grant_d = grant;
            end else if (grant_empty) begin
               tmo_d = tmo_cnt + 1'b1;
            end
         end
`ifdef UART_ARB_PREFIX_EN
         ST_PFX0: begin
            out_valid = 1'b1;
            out_ch    = PFX_OPEN;
            if (out_ready) state_d = ST_PFX1;
         end
         ST_PFX1: begin
            out_valid = 1'b1;
            out_ch    = PFX_DIGIT_BASE + 8'(grant);
            if (out_ready) state_d = ST_PFX2;
         end
         ST_PFX2: begin
            out_valid = 1'b1;
            out_ch    = PFX_CLOSE;
            if (out_ready) state_d = ST_PFX3;
         end
         ST_PFX3: begin
            out_valid = 1'b1;
            out_ch    = PFX_SPACE;
            if (out_ready) begin
               state_d = ST_LOCK;
               tmo_d   = '0;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         grant        <= '0;
         last_grant   <= SW'(NUM_SRC - 1);
         tmo_cnt      <= '0;
         src_overflow <= '0;
      end else begin
         state        <= state_d;
         grant        <= grant_d;
         last_grant   <= last_grant_d;
         tmo_cnt      <= tmo_d;
         src_overflow <= src_overflow | (src_valid & full & ~pop);
      end
   end

endmodule

// File: tb/tb_uart_line_arbiter.sv
// tb/tb_uart_line_arbiter.sv - directed bench for uart_line_arbiter (NUM_SRC=2, FIFO_DEPTH=4, LOCK_TIMEOUT=8)
// Prefix expectations follow UART_ARB_PREFIX_EN when it is defined.
module tb_uart_line_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  src_valid = '0;
   logic [15:0] src_ch = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [7:0]  out_ch;
   logic [0:0]  out_src;
   logic [1:0]  src_overflow;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [7:0] got_ch[$];
   int         got_src[$];
   int         got_cyc[$];

   uart_line_arbiter #(
      .NUM_SRC      (2),
      .FIFO_DEPTH   (4),
      .LOCK_TIMEOUT (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .src_valid    (src_valid),
      .src_ch       (src_ch),
      .out_valid    (out_valid),
      .out_ch       (out_ch),
      .out_src      (out_src),
      .out_ready    (out_ready),
      .src_overflow (src_overflow)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         got_ch.push_back(out_ch);
         got_src.push_back(int'(out_src));
         got_cyc.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_log();
      got_ch.delete();
      got_src.delete();
      got_cyc.delete();
   endtask

   task automatic drive(input logic v0, input logic [7:0] c0, input logic v1, input logic [7:0] c1);
      src_valid = {v1, v0};
      src_ch    = {c1, c0};
      step();
   endtask

   task automatic wait_n(input int n, input int budget);
      int k = 0;
      while (got_ch.size() < n && k < budget) begin
         step();
         k++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
      n_checks++; if (out_ch !== 8'h00) begin n_fail++; $display("FAIL reset_out_ch got %0h want 00", out_ch); end
      n_checks++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL reset_out_src got %0h want 0", out_src); end
      n_checks++; if (src_overflow !== 2'b00) begin n_fail++; $display("FAIL reset_overflow got %0h want 0", src_overflow); end
   endtask

   task automatic test_interleave();
      string      exp;
      logic [7:0] e;
      int         t0;
      exp = "ab\ncd\n";
      out_ready = 1'b1;
      clear_log();
      t0 = cyc;
      drive(1'b1, "a", 1'b1, "c");
      drive(1'b1, "b", 1'b1, "d");
      drive(1'b1, 8'h0A, 1'b1, 8'h0A);
      src_valid = '0;
      wait_n(6, 40);
      n_checks++; if (got_ch.size() !== 6) begin n_fail++; $display("FAIL interleave_count got %0d want 6", got_ch.size()); end
      for (int i = 0; i < 6; i++) begin
         if (i < got_ch.size()) begin
            e = exp[i];
            n_checks++; if (got_ch[i] !== e) begin n_fail++; $display("FAIL interleave_ch[%0d] got %0h want %0h", i, got_ch[i], e); end
            n_checks++; if (got_src[i] !== ((i < 3) ? 0 : 1)) begin n_fail++; $display("FAIL interleave_src[%0d] got %0d want %0d", i, got_src[i], (i < 3) ? 0 : 1); end
         end
      end
      if (got_cyc.size() >= 4) begin
         n_checks++; if (got_cyc[0] !== t0 + 2) begin n_fail++; $display("FAIL interleave_first_cycle got %0d want %0d", got_cyc[0], t0 + 2); end
         n_checks++; if (got_cyc[3] !== t0 + 6) begin n_fail++; $display("FAIL interleave_regrant_cycle got %0d want %0d", got_cyc[3], t0 + 6); end
      end
   endtask

   task automatic test_timeout();
      int t0;
      out_ready = 1'b1;
      clear_log();
      t0 = cyc;
      drive(1'b1, "x", 1'b0, 8'h00);
      drive(1'b0, 8'h00, 1'b1, "y");
      drive(1'b0, 8'h00, 1'b1, 8'h0A);
      src_valid = '0;
      wait_n(3, 40);
      n_checks++; if (got_ch.size() !== 3) begin n_fail++; $display("FAIL timeout_count got %0d want 3", got_ch.size()); end
      if (got_ch.size() >= 3) begin
         n_checks++; if (got_ch[0] !== "x" || got_src[0] !== 0) begin n_fail++; $display("FAIL timeout_first got %0h/src%0d want 78/src0", got_ch[0], got_src[0]); end
         n_checks++; if (got_cyc[0] !== t0 + 2) begin n_fail++; $display("FAIL timeout_x_cycle got %0d want %0d", got_cyc[0], t0 + 2); end
         n_checks++; if (got_ch[1] !== "y" || got_src[1] !== 1) begin n_fail++; $display("FAIL timeout_second got %0h/src%0d want 79/src1", got_ch[1], got_src[1]); end
         n_checks++; if (got_cyc[1] !== t0 + 13) begin n_fail++; $display("FAIL timeout_release_cycle got %0d want %0d", got_cyc[1], t0 + 13); end
         n_checks++; if (got_ch[2] !== 8'h0A || got_src[2] !== 1) begin n_fail++; $display("FAIL timeout_third got %0h/src%0d want 0a/src1", got_ch[2], got_src[2]); end
      end
   endtask

   task automatic test_overflow();
      string      exp;
      logic [7:0] e;
      exp = "1234";
      out_ready = 1'b0;
      clear_log();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'(8'h31 + i), 1'b0, 8'h00);
         if (i == 3) begin
            n_checks++; if (src_overflow !== 2'b00) begin n_fail++; $display("FAIL overflow_after_4th got %0h want 0", src_overflow); end
         end
         if (i == 4) begin
            n_checks++; if (src_overflow !== 2'b01) begin n_fail++; $display("FAIL overflow_after_5th got %0h want 1", src_overflow); end
         end
      end
      src_valid = '0;
      n_checks++; if (out_valid !== 1'b1 || out_ch !== "1") begin n_fail++; $display("FAIL overflow_head got v%0h/%0h want v1/31", out_valid, out_ch); end
      out_ready = 1'b1;
      wait_n(4, 20);
      repeat (15) step();
      n_checks++; if (got_ch.size() !== 4) begin n_fail++; $display("FAIL overflow_buffered got %0d want 4", got_ch.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < got_ch.size()) begin
            e = exp[i];
            n_checks++; if (got_ch[i] !== e) begin n_fail++; $display("FAIL overflow_ch[%0d] got %0h want %0h", i, got_ch[i], e); end
         end
      end
      n_checks++; if (src_overflow !== 2'b01) begin n_fail++; $display("FAIL overflow_sticky got %0h want 1", src_overflow); end
   endtask

   task automatic test_full_push_pop();
      string      exp;
      logic [7:0] e;
      int         t0;
      exp = "ABCDEF\n";
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++; if (src_overflow !== 2'b00) begin n_fail++; $display("FAIL overflow_cleared_by_reset got %0h want 0", src_overflow); end
      out_ready = 1'b0;
      clear_log();
      t0 = cyc;
      drive(1'b1, "A", 1'b0, 8'h00);
      drive(1'b1, "B", 1'b0, 8'h00);
      drive(1'b1, "C", 1'b0, 8'h00);
      drive(1'b1, "D", 1'b0, 8'h00);
      out_ready = 1'b1;
      drive(1'b1, "E", 1'b0, 8'h00);
      drive(1'b1, "F", 1'b0, 8'h00);
      drive(1'b1, 8'h0A, 1'b0, 8'h00);
      src_valid = '0;
      wait_n(7, 30);
      n_checks++; if (got_ch.size() !== 7) begin n_fail++; $display("FAIL pushpop_count got %0d want 7", got_ch.size()); end
      for (int i = 0; i < 7; i++) begin
         if (i < got_ch.size()) begin
            e = exp[i];
            n_checks++; if (got_ch[i] !== e) begin n_fail++; $display("FAIL pushpop_ch[%0d] got %0h want %0h", i, got_ch[i], e); end
         end
      end
      if (got_cyc.size() >= 7) begin
         n_checks++; if (got_cyc[0] !== t0 + 4) begin n_fail++; $display("FAIL pushpop_first_cycle got %0d want %0d", got_cyc[0], t0 + 4); end
         n_checks++; if (got_cyc[6] !== t0 + 10) begin n_fail++; $display("FAIL pushpop_last_cycle got %0d want %0d", got_cyc[6], t0 + 10); end
      end
      n_checks++; if (src_overflow !== 2'b00) begin n_fail++; $display("FAIL pushpop_overflow got %0h want 0", src_overflow); end
   endtask

   task automatic test_prefix();
      string      exp;
      logic [7:0] e;
      int         t0;
`ifdef UART_ARB_PREFIX_EN
      exp = "[1] hi\n";
`else
      exp = "hi\n";
`endif
      out_ready = 1'b1;
      clear_log();
      t0 = cyc;
      drive(1'b0, 8'h00, 1'b1, "h");
      drive(1'b0, 8'h00, 1'b1, "i");
      drive(1'b0, 8'h00, 1'b1, 8'h0A);
      src_valid = '0;
      wait_n(exp.len(), 40);
      n_checks++; if (got_ch.size() !== exp.len()) begin n_fail++; $display("FAIL prefix_count got %0d want %0d", got_ch.size(), exp.len()); end
      for (int i = 0; i < exp.len(); i++) begin
         if (i < got_ch.size()) begin
            e = exp[i];
            n_checks++; if (got_ch[i] !== e || got_src[i] !== 1) begin n_fail++; $display("FAIL prefix_ch[%0d] got %0h/src%0d want %0h/src1", i, got_ch[i], got_src[i], e); end
         end
      end
      if (got_cyc.size() >= exp.len()) begin
         n_checks++; if (got_cyc[0] !== t0 + 2) begin n_fail++; $display("FAIL prefix_first_cycle got %0d want %0d", got_cyc[0], t0 + 2); end
         n_checks++; if (got_cyc[exp.len() - 1] !== t0 + 1 + exp.len()) begin n_fail++; $display("FAIL prefix_last_cycle got %0d want %0d", got_cyc[exp.len() - 1], t0 + 1 + exp.len()); end
      end
   endtask

   task automatic test_reset_midline();
      out_ready = 1'b1;
      clear_log();
      drive(1'b1, "q", 1'b0, 8'h00);
      drive(1'b1, 8'h0A, 1'b0, 8'h00);
      src_valid = '0;
      wait_n(2, 20);
      step();
      step();
      out_ready = 1'b0;
      drive(1'b0, 8'h00, 1'b1, "r");
      drive(1'b0, 8'h00, 1'b1, "s");
      drive(1'b0, 8'h00, 1'b1, "t");
      src_valid = '0;
      n_checks++; if (out_valid !== 1'b1 || out_src !== 1'b1) begin n_fail++; $display("FAIL midline_locked got v%0h/src%0h want v1/src1", out_valid, out_src); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midline_reset_valid got %0h want 0", out_valid); end
      n_checks++; if (out_src !== 1'b0 || out_ch !== 8'h00) begin n_fail++; $display("FAIL midline_reset_outputs got src%0h/%0h want src0/00", out_src, out_ch); end
      repeat (3) step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midline_fifos_empty got out_valid %0h want 0", out_valid); end
      out_ready = 1'b1;
      clear_log();
      drive(1'b1, "u", 1'b1, "v");
      src_valid = '0;
      wait_n(1, 20);
      n_checks++; if (got_ch.size() < 1) begin n_fail++; $display("FAIL midline_next_grant got %0d transfers want 1", got_ch.size()); end
      else if (got_src[0] !== 0 || got_ch[0] !== "u") begin n_fail++; $display("FAIL midline_next_grant got %0h/src%0d want 75/src0", got_ch[0], got_src[0]); end
   endtask

   initial begin
      test_reset();
      test_interleave();
      test_timeout();
      test_overflow();
      test_full_push_pop();
      test_prefix();
      test_reset_midline();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
